// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage: widths, load funct3 codes,
// the arbitration select type and the load extension helpers.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LSU  = 2'd2
  } wb_sel_e;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic is_signed);
    return {{(XLEN-8){is_signed & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic is_signed);
    return {{(XLEN-16){is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundles the ALU/LSU result handshakes, issue port, scoreboard and register-file
// write port of the writeback stage; slave is the stage, master is whoever drives it.
interface wb_stage_if;
  import wb_pkg::*;

  logic             alu_valid_i;
  logic             alu_ready_o;
  logic [AW-1:0]    alu_rd_addr_i;
  logic [XLEN-1:0]  alu_data_i;
  logic             lsu_valid_i;
  logic             lsu_ready_o;
  logic [AW-1:0]    lsu_rd_addr_i;
  logic [XLEN-1:0]  lsu_rdata_i;
  logic [2:0]       lsu_funct3_i;
  logic [1:0]       lsu_off_i;
  logic             issue_i;
  logic [AW-1:0]    issue_rd_i;
  logic [NREG-1:0]  busy_o;
  logic [AW-1:0]    rd_addr_o;
  logic [XLEN-1:0]  rd_data_o;
  logic             rd_wren_o;
  logic             load_err_o;

  modport slave (
    input  alu_valid_i, alu_rd_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_off_i,
    input  issue_i, issue_rd_i,
    output alu_ready_o, lsu_ready_o, busy_o,
    output rd_addr_o, rd_data_o, rd_wren_o, load_err_o
  );

  modport master (
    output alu_valid_i, alu_rd_addr_i, alu_data_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_off_i,
    output issue_i, issue_rd_i,
    input  alu_ready_o, lsu_ready_o, busy_o,
    input  rd_addr_o, rd_data_o, rd_wren_o, load_err_o
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: picks the addressed byte/half of the raw word,
// sign- or zero-extends it, and flags illegal funct3 codes and misaligned accesses.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = {XLEN{1'b0}};
    o_err  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = ext8(w_byte, 1'b1);
      F3_LBU: o_data = ext8(w_byte, 1'b0);
      F3_LH:  begin o_data = ext16(w_half, 1'b1); o_err = i_off[0]; end
      F3_LHU: begin o_data = ext16(w_half, 1'b0); o_err = i_off[0]; end
      F3_LW:  begin o_data = i_rdata;             o_err = (i_off != 2'd0); end
      default: begin o_data = {XLEN{1'b0}};       o_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU vs LSU results with an anti-starvation limit,
// registers one register-file write per cycle and tracks pending writes in busy_o.
module wb_stage
  import wb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_stage_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   r_starve;
  logic [AW-1:0]   r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic            r_rd_wren;
  logic            r_load_err;
  logic [NREG-1:0] r_busy;

  logic            w_alu_win;
  wb_sel_e         w_sel;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_err;
  logic [NREG-1:0] w_busy_nxt;

  load_align u_align (
    .i_rdata  (bus.lsu_rdata_i),
    .i_funct3 (bus.lsu_funct3_i),
    .i_off    (bus.lsu_off_i),
    .o_data   (w_ld_data),
    .o_err    (w_ld_err)
  );

  // LSU wins unless it is idle or the ALU has already lost STARVE_MAX cycles in a row.
  always_comb begin
    w_alu_win = bus.alu_valid_i & (~bus.lsu_valid_i | (r_starve == SW'(STARVE_MAX)));
    w_sel     = SEL_NONE;
    if (rst_i)                w_sel = SEL_NONE;
    else if (w_alu_win)       w_sel = SEL_ALU;
    else if (bus.lsu_valid_i) w_sel = SEL_LSU;
    else                      w_sel = SEL_NONE;
  end

  assign bus.alu_ready_o = (w_sel == SEL_ALU);
  assign bus.lsu_ready_o = (w_sel == SEL_LSU);

  // Clear the accepted destination first so a same-cycle issue to it keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    case (w_sel)
      SEL_ALU: w_busy_nxt[bus.alu_rd_addr_i] = 1'b0;
      SEL_LSU: w_busy_nxt[bus.lsu_rd_addr_i] = 1'b0;
      default: w_busy_nxt = r_busy;
    endcase
    w_busy_nxt[bus.issue_rd_i] = w_busy_nxt[bus.issue_rd_i] | bus.issue_i;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve   <= {SW{1'b0}};
      r_rd_addr  <= {AW{1'b0}};
      r_rd_data  <= {XLEN{1'b0}};
      r_rd_wren  <= 1'b0;
      r_load_err <= 1'b0;
      r_busy     <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
      if (bus.alu_valid_i && (w_sel != SEL_ALU)) begin
        r_starve <= (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + SW'(1);
      end else begin
        r_starve <= {SW{1'b0}};
      end
      case (w_sel)
        SEL_ALU: begin
          r_rd_addr  <= bus.alu_rd_addr_i;
          r_rd_data  <= bus.alu_data_i;
          r_rd_wren  <= (bus.alu_rd_addr_i != {AW{1'b0}});
          r_load_err <= 1'b0;
        end
        SEL_LSU: begin
          r_rd_addr  <= bus.lsu_rd_addr_i;
          r_rd_data  <= w_ld_data;
          r_rd_wren  <= ~w_ld_err & (bus.lsu_rd_addr_i != {AW{1'b0}});
          r_load_err <= w_ld_err;
        end
        default: begin
          r_rd_wren  <= 1'b0;
          r_load_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.rd_wren_o  = r_rd_wren;
  assign bus.load_err_o = r_load_err;
  assign bus.busy_o     = r_busy;

endmodule
